// File: rtl/div_issue_ctrl.sv
// rtl/div_issue_ctrl.sv - issue/timeout controller wrapping an iterative divider core
// Accepts one request, sequences LOAD/RUN on the core, and holds the result until consumed.
module div_issue_ctrl #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 40
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_dividend,
    input  logic [WIDTH-1:0] in_divisor,
    output logic             core_rst,
    output logic             core_run,
    output logic [WIDTH-1:0] core_dividend,
    output logic [WIDTH-1:0] core_divisor,
    input  logic             core_rdy,
    input  logic [WIDTH-1:0] core_quotient,
    input  logic [WIDTH-1:0] core_remainder,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quotient,
    output logic [WIDTH-1:0] out_remainder,
    output logic             out_dz,
    output logic             out_to,
    output logic [5:0]       out_cycles
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, OUT} state_t;

    state_t           state, state_nx;
    logic [5:0]       cnt;
    logic [WIDTH-1:0] dvd_r, dvs_r, q_r, r_r;
    logic             dz_r, to_r;
    logic [5:0]       cyc_r;
    logic             accept, div_zero, timeout_hit;

    assign accept      = (state == IDLE) && in_valid;
    assign div_zero    = (in_divisor == '0);
    assign timeout_hit = (cnt == 6'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (in_valid) state_nx = div_zero ? OUT : LOAD;
            LOAD: state_nx = RUN;
            RUN:  if (core_rdy || timeout_hit) state_nx = OUT;
            OUT:  if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Handshake/core strobes; rst overrides so the core is held in reset with us.
    always_comb begin
        in_ready  = 1'b0;
        core_rst  = 1'b0;
        core_run  = 1'b0;
        out_valid = 1'b0;
        if (rst) begin
            core_rst = 1'b1;
        end else begin
            case (state)
                IDLE:    in_ready  = 1'b1;
                LOAD:    core_rst  = 1'b1;
                RUN:     core_run  = 1'b1;
                OUT:     out_valid = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dvd_r <= '0;
            dvs_r <= '0;
            q_r   <= '0;
            r_r   <= '0;
            dz_r  <= 1'b0;
            to_r  <= 1'b0;
            cyc_r <= '0;
            cnt   <= '0;
        end else begin
            if (accept) begin
                dvd_r <= in_dividend;
                dvs_r <= in_divisor;
                if (div_zero) begin
                    q_r   <= '1;
                    r_r   <= in_dividend;
                    dz_r  <= 1'b1;
                    to_r  <= 1'b0;
                    cyc_r <= '0;
                end
            end
            if (state == LOAD) cnt <= '0;
            if (state == RUN) begin
                cnt <= cnt + 6'd1;
                // A late core_rdy on the final allowed cycle still wins over the timeout.
                if (core_rdy) begin
                    q_r   <= core_quotient;
                    r_r   <= core_remainder;
                    dz_r  <= 1'b0;
                    to_r  <= 1'b0;
                    cyc_r <= cnt + 6'd1;
                end else if (timeout_hit) begin
                    q_r   <= '0;
                    r_r   <= '0;
                    dz_r  <= 1'b0;
                    to_r  <= 1'b1;
                    cyc_r <= 6'(TIMEOUT);
                end
            end
        end
    end

    assign core_dividend = rst ? '0 : dvd_r;
    assign core_divisor  = rst ? '0 : dvs_r;
    assign out_quotient  = rst ? '0 : q_r;
    assign out_remainder = rst ? '0 : r_r;
    assign out_dz        = rst ? 1'b0 : dz_r;
    assign out_to        = rst ? 1'b0 : to_r;
    assign out_cycles    = rst ? 6'd0 : cyc_r;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb/tb_div_issue_ctrl.sv - directed scoreboard bench for div_issue_ctrl with a stub core
module tb_div_issue_ctrl;

    localparam int W  = 32;
    localparam int TO = 40;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_dividend = '0;
    logic [W-1:0]  in_divisor = '0;
    logic          core_rst, core_run;
    logic [W-1:0]  core_dividend, core_divisor;
    logic          core_rdy;
    logic [W-1:0]  core_quotient, core_remainder;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_quotient, out_remainder;
    logic          out_dz, out_to;
    logic [5:0]    out_cycles;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         to;
        logic [5:0]   cyc;
    } exp_t;

    exp_t sb[$];
    int   compared = 0;
    int   mismatched = 0;
    int   rdy_at = 0;
    int   stub_cnt = 0;

    always #5 clk = ~clk;

    div_issue_ctrl #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_dividend(in_dividend), .in_divisor(in_divisor),
        .core_rst(core_rst), .core_run(core_run),
        .core_dividend(core_dividend), .core_divisor(core_divisor),
        .core_rdy(core_rdy), .core_quotient(core_quotient), .core_remainder(core_remainder),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_quotient(out_quotient), .out_remainder(out_remainder),
        .out_dz(out_dz), .out_to(out_to), .out_cycles(out_cycles)
    );

    // Stub core: answers on its rdy_at-th run cycle (0 = never answers).
    always_ff @(posedge clk) begin
        if (core_rst)      stub_cnt <= 0;
        else if (core_run) stub_cnt <= stub_cnt + 1;
    end
    assign core_rdy       = core_run && (rdy_at != 0) && (stub_cnt == rdy_at - 1);
    assign core_quotient  = (core_divisor != 0) ? core_dividend / core_divisor : '0;
    assign core_remainder = (core_divisor != 0) ? core_dividend % core_divisor : '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                         input int rdy_i, input int hold, input exp_t e);
        exp_t got;
        int k, loads, runs, both;
        sb.push_back(e);
        rdy_at = rdy_i;
        @(negedge clk);
        in_dividend = dvd;
        in_divisor  = dvs;
        in_valid    = 1'b1;
        chk("in_ready_idle", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        k = 0; loads = 0; runs = 0; both = 0;
        while (!out_valid && k < 200) begin
            if (core_rst) loads++;
            if (core_run) runs++;
            if (core_rst && core_run) both++;
            @(negedge clk);
            k++;
        end
        chk("latency", 64'(k), (dvs == 0) ? 64'd0 : 64'(e.cyc) + 64'd1);
        chk("load_cycles", 64'(loads), (dvs == 0) ? 64'd0 : 64'd1);
        chk("run_cycles", 64'(runs), 64'(e.cyc));
        chk("rst_run_overlap", 64'(both), 64'd0);
        got = sb.pop_front();
        chk("quotient", 64'(out_quotient), 64'(got.q));
        chk("remainder", 64'(out_remainder), 64'(got.r));
        chk("dz", 64'(out_dz), 64'(got.dz));
        chk("to", 64'(out_to), 64'(got.to));
        chk("cycles", 64'(out_cycles), 64'(got.cyc));
        for (int i = 0; i < hold; i++) begin
            in_valid    = 1'b1;
            in_dividend = $urandom;
            in_divisor  = '0;
            @(negedge clk);
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
            chk("hold_quotient", 64'(out_quotient), 64'(got.q));
            chk("hold_remainder", 64'(out_remainder), 64'(got.r));
            chk("hold_operand", 64'(core_dividend), 64'(dvd));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("drain_valid", 64'(out_valid), 64'd0);
        chk("drain_in_ready", 64'(in_ready), 64'd1);
        chk("drain_keep_q", 64'(out_quotient), 64'(got.q));
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_core_rst", 64'(core_rst), 64'd1);
        chk("rst_core_run", 64'(core_run), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_cycles", 64'(out_cycles), 64'd0);
        chk("rst_operand", 64'(core_dividend), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        do_op(32'd100, 32'd7, 35, 2, '{q: 32'd14, r: 32'd2, dz: 1'b0, to: 1'b0, cyc: 6'd35});
        do_op(32'd5, 32'd0, 0, 0, '{q: 32'hFFFF_FFFF, r: 32'd5, dz: 1'b1, to: 1'b0, cyc: 6'd0});
        do_op(32'd1000, 32'd3, 0, 1, '{q: 32'd0, r: 32'd0, dz: 1'b0, to: 1'b1, cyc: 6'd40});
        do_op(32'hFFFF_FFFF, 32'd1, 3, 10, '{q: 32'hFFFF_FFFF, r: 32'd0, dz: 1'b0, to: 1'b0, cyc: 6'd3});
        do_op(32'd77, 32'd10, TO, 0, '{q: 32'd7, r: 32'd7, dz: 1'b0, to: 1'b0, cyc: 6'd40});

        // Abort mid-RUN: start a never-answering op, reset on RUN cycle 10.
        rdy_at = 0;
        @(negedge clk);
        in_dividend = 32'd100;
        in_divisor  = 32'd7;
        in_valid    = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("midrun_running", 64'(core_run), 64'd1);
        rst = 1'b1;
        #1;
        chk("midrun_rst_core_run", 64'(core_run), 64'd0);
        chk("midrun_rst_core_rst", 64'(core_rst), 64'd1);
        chk("midrun_rst_quotient", 64'(out_quotient), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrun_after_in_ready", 64'(in_ready), 64'd1);
        chk("midrun_after_out_valid", 64'(out_valid), 64'd0);
        chk("midrun_after_core_run", 64'(core_run), 64'd0);
        chk("midrun_after_operand", 64'(core_dividend), 64'd0);
        do_op(32'd9, 32'd3, 4, 0, '{q: 32'd3, r: 32'd0, dz: 1'b0, to: 1'b0, cyc: 6'd4});

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
